// File: rtl/round_referee.sv
// round_referee: per-round sequencer between the two players and the fighter FSMs.
// Collects one action per player (AWAIT fills in for a player who misses the timeout),
// strobes actionEnable with stable actions, then samples health to decide the game.
module round_referee #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ENABLE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned MAX_ROUNDS     = 0,
    parameter int unsigned ROUND_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p1_valid,
    input  logic [2:0]         p1_action,
    input  logic               p2_valid,
    input  logic [2:0]         p2_action,
    input  logic [1:0]         health1,
    input  logic [1:0]         health2,
    output logic               p1_ack,
    output logic               p2_ack,
    output logic [2:0]         action1,
    output logic [2:0]         action2,
    output logic               actionEnable,
    output logic               isGameOver,
    output logic [1:0]         winner,
    output logic [ROUND_W-1:0] round_count
);

    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned PMAX = (ENABLE_CYCLES > SETTLE_CYCLES) ? ENABLE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned PW   = $clog2(PMAX + 1);

    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] ENABLE_LAST = PW'(ENABLE_CYCLES - 1);
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    ACT_AWAIT   = 3'b010;

    typedef enum logic [2:0] {
        S_COLLECT,
        S_FIRE,
        S_SETTLE,
        S_CHECK,
        S_OVER
    } state_t;

    state_t               r_state,      w_state;
    logic [TW-1:0]        r_timer,      w_timer;
    logic [PW-1:0]        r_phase,      w_phase;
    logic                 r_p1Latched,  w_p1Latched;
    logic                 r_p2Latched,  w_p2Latched;
    logic [2:0]           r_p1Act,      w_p1Act;
    logic [2:0]           r_p2Act,      w_p2Act;
    logic                 r_p1Ack,      w_p1Ack;
    logic                 r_p2Ack,      w_p2Ack;
    logic [2:0]           r_action1,    w_action1;
    logic [2:0]           r_action2,    w_action2;
    logic                 r_enable,     w_enable;
    logic                 r_gameOver,   w_gameOver;
    logic [1:0]           r_winner,     w_winner;
    logic [ROUND_W-1:0]   r_roundCount, w_roundCount;
    logic                 w_timeout;
    logic                 w_decided;
    logic [1:0]           w_verdict;
    logic                 w_limitHit;

    assign p1_ack       = r_p1Ack;
    assign p2_ack       = r_p2Ack;
    assign action1      = r_action1;
    assign action2      = r_action2;
    assign actionEnable = r_enable;
    assign isGameOver   = r_gameOver;
    assign winner       = r_winner;
    assign round_count  = r_roundCount;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_state      = r_state;
        w_timer      = r_timer;
        w_phase      = r_phase;
        w_p1Latched  = r_p1Latched;
        w_p2Latched  = r_p2Latched;
        w_p1Act      = r_p1Act;
        w_p2Act      = r_p2Act;
        w_p1Ack      = 1'b0;
        w_p2Ack      = 1'b0;
        w_action1    = r_action1;
        w_action2    = r_action2;
        w_enable     = r_enable;
        w_gameOver   = r_gameOver;
        w_winner     = r_winner;
        w_roundCount = r_roundCount;
        w_timeout    = (r_timer == TIMER_LAST);
        w_decided    = 1'b0;
        w_verdict    = 2'b00;
        w_limitHit   = (MAX_ROUNDS != 0) && (32'(r_roundCount) >= 32'(MAX_ROUNDS));

        case (r_state)
            S_COLLECT: begin
                if (p1_valid && !r_p1Latched) begin
                    w_p1Latched = 1'b1;
                    w_p1Act     = p1_action;
                    w_p1Ack     = 1'b1;
                end
                if (p2_valid && !r_p2Latched) begin
                    w_p2Latched = 1'b1;
                    w_p2Act     = p2_action;
                    w_p2Ack     = 1'b1;
                end
                // A valid arriving on the timeout cycle is already folded into w_pxLatched,
                // so it takes priority over the AWAIT fill below.
                if ((r_p1Latched && r_p2Latched) || (w_timeout && (w_p1Latched || w_p2Latched))) begin
                    w_state      = S_FIRE;
                    w_timer      = '0;
                    w_phase      = '0;
                    w_enable     = 1'b1;
                    w_action1    = w_p1Latched ? w_p1Act : ACT_AWAIT;
                    w_action2    = w_p2Latched ? w_p2Act : ACT_AWAIT;
                    w_roundCount = (&r_roundCount) ? r_roundCount : r_roundCount + 1'b1;
                end else if (w_timeout) begin
                    w_timer = '0;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            S_FIRE: begin
                if (r_phase == ENABLE_LAST) begin
                    w_state  = S_SETTLE;
                    w_phase  = '0;
                    w_enable = 1'b0;
                end else begin
                    w_phase = r_phase + 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_phase == SETTLE_LAST) begin
                    w_state = S_CHECK;
                    w_phase = '0;
                end else begin
                    w_phase = r_phase + 1'b1;
                end
            end
            S_CHECK: begin
                if (health1 == 2'd0 && health2 == 2'd0) begin
                    w_decided = 1'b1;
                    w_verdict = 2'b11;
                end else if (health2 == 2'd0) begin
                    w_decided = 1'b1;
                    w_verdict = 2'b01;
                end else if (health1 == 2'd0) begin
                    w_decided = 1'b1;
                    w_verdict = 2'b10;
                end else if (w_limitHit) begin
                    w_decided = 1'b1;
                    if (health1 > health2) begin
                        w_verdict = 2'b01;
                    end else if (health2 > health1) begin
                        w_verdict = 2'b10;
                    end else begin
                        w_verdict = 2'b11;
                    end
                end
                if (w_decided) begin
                    w_state    = S_OVER;
                    w_gameOver = 1'b1;
                    w_winner   = w_verdict;
                end else begin
                    w_state     = S_COLLECT;
                    w_timer     = '0;
                    w_p1Latched = 1'b0;
                    w_p2Latched = 1'b0;
                    w_p1Act     = ACT_AWAIT;
                    w_p2Act     = ACT_AWAIT;
                end
            end
            S_OVER: begin
                w_enable = 1'b0;
            end
            default: begin
                w_state = S_COLLECT;
            end
        endcase
    end

    // State and output registers; reset returns to an idle COLLECT with AWAIT actions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_COLLECT;
            r_timer      <= '0;
            r_phase      <= '0;
            r_p1Latched  <= 1'b0;
            r_p2Latched  <= 1'b0;
            r_p1Act      <= ACT_AWAIT;
            r_p2Act      <= ACT_AWAIT;
            r_p1Ack      <= 1'b0;
            r_p2Ack      <= 1'b0;
            r_action1    <= ACT_AWAIT;
            r_action2    <= ACT_AWAIT;
            r_enable     <= 1'b0;
            r_gameOver   <= 1'b0;
            r_winner     <= 2'b00;
            r_roundCount <= '0;
        end else begin
            r_state      <= w_state;
            r_timer      <= w_timer;
            r_phase      <= w_phase;
            r_p1Latched  <= w_p1Latched;
            r_p2Latched  <= w_p2Latched;
            r_p1Act      <= w_p1Act;
            r_p2Act      <= w_p2Act;
            r_p1Ack      <= w_p1Ack;
            r_p2Ack      <= w_p2Ack;
            r_action1    <= w_action1;
            r_action2    <= w_action2;
            r_enable     <= w_enable;
            r_gameOver   <= w_gameOver;
            r_winner     <= w_winner;
            r_roundCount <= w_roundCount;
        end
    end

endmodule

// File: tb/tb_round_referee.sv
// tb_round_referee: scoreboard bench for round_referee.
// Three instances share the stimulus: default parameters, a 3-round limit, and a 2-bit round counter.
module tb_round_referee;

    localparam int ENABLE_CYCLES = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p1_valid = 1'b0;
    logic       p2_valid = 1'b0;
    logic [2:0] p1_action = 3'b000;
    logic [2:0] p2_action = 3'b000;
    logic [1:0] health1 = 2'd3;
    logic [1:0] health2 = 2'd3;

    logic       dP1Ack, dP2Ack, dEnable, dOver;
    logic [2:0] dAct1, dAct2;
    logic [1:0] dWinner;
    logic [7:0] dRound;

    logic       lP1Ack, lP2Ack, lEnable, lOver;
    logic [2:0] lAct1, lAct2;
    logic [1:0] lWinner;
    logic [7:0] lRound;

    logic       sP1Ack, sP2Ack, sEnable, sOver;
    logic [2:0] sAct1, sAct2;
    logic [1:0] sWinner;
    logic [1:0] sRound;

    round_referee dut (
        .clk(clk), .reset(reset),
        .p1_valid(p1_valid), .p1_action(p1_action),
        .p2_valid(p2_valid), .p2_action(p2_action),
        .health1(health1), .health2(health2),
        .p1_ack(dP1Ack), .p2_ack(dP2Ack),
        .action1(dAct1), .action2(dAct2),
        .actionEnable(dEnable), .isGameOver(dOver),
        .winner(dWinner), .round_count(dRound)
    );

    round_referee #(.MAX_ROUNDS(3)) dutLim (
        .clk(clk), .reset(reset),
        .p1_valid(p1_valid), .p1_action(p1_action),
        .p2_valid(p2_valid), .p2_action(p2_action),
        .health1(health1), .health2(health2),
        .p1_ack(lP1Ack), .p2_ack(lP2Ack),
        .action1(lAct1), .action2(lAct2),
        .actionEnable(lEnable), .isGameOver(lOver),
        .winner(lWinner), .round_count(lRound)
    );

    round_referee #(.ROUND_W(2)) dutSat (
        .clk(clk), .reset(reset),
        .p1_valid(p1_valid), .p1_action(p1_action),
        .p2_valid(p2_valid), .p2_action(p2_action),
        .health1(health1), .health2(health2),
        .p1_ack(sP1Ack), .p2_ack(sP2Ack),
        .action1(sAct1), .action2(sAct2),
        .actionEnable(sEnable), .isGameOver(sOver),
        .winner(sWinner), .round_count(sRound)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] a1;
        logic [2:0] a2;
        logic [7:0] rc;
    } roundExp_t;

    roundExp_t expQ[$];
    int checks = 0;
    int errors = 0;
    int roundsSeen = 0;
    int p2AckCount = 0;
    int expRound = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        reset    = 1'b1;
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        health1  = 2'd3;
        health2  = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        expRound   = 0;
        p2AckCount = 0;
    endtask

    task automatic pushExp(input logic [2:0] a1, input logic [2:0] a2);
        roundExp_t e;
        expRound++;
        e.a1 = a1;
        e.a2 = a2;
        e.rc = 8'(expRound);
        expQ.push_back(e);
    endtask

    // Both players submit in one cycle; healths are changed on SETTLE entry, returns after CHECK.
    task automatic applyStimulus(input logic [2:0] a1, input logic [2:0] a2,
                                 input logic [1:0] h1, input logic [1:0] h2);
        p1_valid  = 1'b1;
        p2_valid  = 1'b1;
        p1_action = a1;
        p2_action = a2;
        pushExp(a1, a2);
        tick();
        checkOutput("bothAck", {30'd0, dP1Ack, dP2Ack}, 32'd3);
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        repeat (3) tick();
        health1 = h1;
        health2 = h2;
        repeat (3) tick();
    endtask

    // Scoreboard monitor: every rising actionEnable pops one expected round.
    initial begin
        roundExp_t e;
        logic prevEn;
        int   enHigh;
        prevEn = 1'b0;
        enHigh = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevEn = 1'b0;
                enHigh = 0;
            end else begin
                if (dP2Ack) p2AckCount++;
                if (dEnable && !prevEn) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedRound", 32'd1, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("sbAction1", 32'(dAct1), 32'(e.a1));
                        checkOutput("sbAction2", 32'(dAct2), 32'(e.a2));
                        checkOutput("sbRound", 32'(dRound), 32'(e.rc));
                    end
                    roundsSeen++;
                end
                if (dEnable) enHigh++;
                if (!dEnable && prevEn) begin
                    checkOutput("enWidth", 32'(enHigh), 32'(ENABLE_CYCLES));
                    enHigh = 0;
                end
                prevEn = dEnable;
            end
        end
    end

    logic [1:0] koH1[3] = '{2'd3, 2'd0, 2'd0};
    logic [1:0] koH2[3] = '{2'd0, 2'd2, 2'd0};
    logic [1:0] koWin[3] = '{2'b01, 2'b10, 2'b11};
    logic [1:0] limH1[3] = '{2'd3, 2'd2, 2'd1};
    logic [1:0] limH2[3] = '{2'd2, 2'd2, 2'd3};
    logic [1:0] limWin[3] = '{2'b01, 2'b11, 2'b10};

    initial begin
        int r0;
        int n;

        // reset values on every instance
        resetDut();
        checkOutput("rstEnD", {31'd0, dEnable}, 32'd0);
        checkOutput("rstAct1D", 32'(dAct1), 32'd2);
        checkOutput("rstAct2D", 32'(dAct2), 32'd2);
        checkOutput("rstRoundD", 32'(dRound), 32'd0);
        checkOutput("rstWinD", 32'(dWinner), 32'd0);
        checkOutput("rstOverD", {31'd0, dOver}, 32'd0);
        checkOutput("rstAckD", {30'd0, dP1Ack, dP2Ack}, 32'd0);
        checkOutput("rstEnL", {31'd0, lEnable}, 32'd0);
        checkOutput("rstActL", {26'd0, lAct1, lAct2}, 32'o22);
        checkOutput("rstRoundL", 32'(lRound), 32'd0);
        checkOutput("rstWinL", {29'd0, lOver, lWinner}, 32'd0);
        checkOutput("rstAckL", {30'd0, lP1Ack, lP2Ack}, 32'd0);
        checkOutput("rstEnS", {31'd0, sEnable}, 32'd0);
        checkOutput("rstActS", {26'd0, sAct1, sAct2}, 32'o22);
        checkOutput("rstRoundS", 32'(sRound), 32'd0);
        checkOutput("rstWinS", {29'd0, sOver, sWinner}, 32'd0);
        checkOutput("rstAckS", {30'd0, sP1Ack, sP2Ack}, 32'd0);

        // idle: the timeout wraps with nothing latched and no round fires
        r0 = roundsSeen;
        repeat (40) tick();
        checkOutput("idleRounds", 32'(roundsSeen), 32'(r0));
        checkOutput("idleRoundCount", 32'(dRound), 32'd0);
        checkOutput("idleEnable", {31'd0, dEnable}, 32'd0);

        // staggered submission, duplicate ignored, then reset in the middle of FIRE
        resetDut();
        repeat (2) tick();
        p1_valid  = 1'b1;
        p1_action = 3'b000;
        tick();
        checkOutput("p1Ack", {31'd0, dP1Ack}, 32'd1);
        checkOutput("p2AckIdle", {31'd0, dP2Ack}, 32'd0);
        p1_action = 3'b110;
        tick();
        checkOutput("p1DupNoAck", {31'd0, dP1Ack}, 32'd0);
        p1_valid  = 1'b0;
        p2_valid  = 1'b1;
        p2_action = 3'b001;
        pushExp(3'b000, 3'b001);
        tick();
        checkOutput("p2Ack", {31'd0, dP2Ack}, 32'd1);
        checkOutput("enBeforeFire", {31'd0, dEnable}, 32'd0);
        p2_valid = 1'b0;
        tick();
        checkOutput("enFire0", {31'd0, dEnable}, 32'd1);
        checkOutput("fireAct1", 32'(dAct1), 32'd0);
        checkOutput("fireAct2", 32'(dAct2), 32'd1);
        checkOutput("fireRound", 32'(dRound), 32'd1);
        tick();
        checkOutput("enFire1", {31'd0, dEnable}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midRstEn", {31'd0, dEnable}, 32'd0);
        checkOutput("midRstAct", {26'd0, dAct1, dAct2}, 32'o22);
        checkOutput("midRstRound", 32'(dRound), 32'd0);
        checkOutput("midRstWin", 32'(dWinner), 32'd0);

        // timeout fill: only p1 submits, p2 is forced to AWAIT on timer 15
        resetDut();
        p1_valid  = 1'b1;
        p1_action = 3'b100;
        pushExp(3'b100, 3'b010);
        tick();
        n = 1;
        p1_valid = 1'b0;
        while (!dEnable && n < 40) begin
            tick();
            n++;
        end
        checkOutput("timeoutLatency", 32'(n), 32'd16);
        checkOutput("timeoutAct1", 32'(dAct1), 32'o4);
        checkOutput("timeoutAct2", 32'(dAct2), 32'o2);
        repeat (8) tick();
        checkOutput("timeoutNoP2Ack", 32'(p2AckCount), 32'd0);

        // a valid on the timeout cycle beats the AWAIT fill
        resetDut();
        p1_valid  = 1'b1;
        p1_action = 3'b000;
        tick();
        p1_valid = 1'b0;
        repeat (14) tick();
        p2_valid  = 1'b1;
        p2_action = 3'b011;
        pushExp(3'b000, 3'b011);
        tick();
        p2_valid = 1'b0;
        checkOutput("lateP2Ack", {31'd0, dP2Ack}, 32'd1);
        checkOutput("lateEnable", {31'd0, dEnable}, 32'd1);
        checkOutput("lateAct2", 32'(dAct2), 32'o3);
        repeat (8) tick();

        // knockouts, then the game stays over
        for (int i = 0; i < 3; i++) begin
            resetDut();
            applyStimulus(3'b001, 3'b000, koH1[i], koH2[i]);
            checkOutput("koWinner", 32'(dWinner), 32'(koWin[i]));
            checkOutput("koOver", {31'd0, dOver}, 32'd1);
            r0 = roundsSeen;
            p1_valid = 1'b1;
            p2_valid = 1'b1;
            tick();
            checkOutput("overNoAck", {30'd0, dP1Ack, dP2Ack}, 32'd0);
            p1_valid = 1'b0;
            p2_valid = 1'b0;
            repeat (20) tick();
            checkOutput("overNoRound", 32'(roundsSeen), 32'(r0));
            checkOutput("overRoundCount", 32'(dRound), 32'd1);
            checkOutput("overWinHeld", 32'(dWinner), 32'(koWin[i]));
        end

        // round limit on dutLim, unlimited rounds and saturation on the others
        for (int i = 0; i < 3; i++) begin
            resetDut();
            for (int k = 0; k < 2; k++) begin
                applyStimulus(3'(k), 3'(7 - k), limH1[i], limH2[i]);
            end
            checkOutput("limNotYet", {31'd0, lOver}, 32'd0);
            applyStimulus(3'b101, 3'b011, limH1[i], limH2[i]);
            checkOutput("limWinner", 32'(lWinner), 32'(limWin[i]));
            checkOutput("limOver", {31'd0, lOver}, 32'd1);
            checkOutput("limRound", 32'(lRound), 32'd3);
            checkOutput("unlimNotOver", {31'd0, dOver}, 32'd0);
            applyStimulus(3'b111, 3'b000, limH1[i], limH2[i]);
            applyStimulus(3'b010, 3'b110, limH1[i], limH2[i]);
            checkOutput("satRound", 32'(sRound), 32'd3);
            checkOutput("fullRound", 32'(dRound), 32'd5);
            checkOutput("limRoundHeld", 32'(lRound), 32'd3);
        end

        checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
